// File: rtl/freq_meter_pkg.sv
// Shared types and default constants for the gated-window frequency meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } state_t;

  // 48 MHz system clock, 6 MHz target, 1 ms gate.
  localparam int unsigned DEF_GATE_CYCLES = 48000;
  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_EXP_MIN     = 5990;
  localparam int unsigned DEF_EXP_MAX     = 6010;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned width_for(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a rising-edge detector on the synchronized level.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign sync_out = sync2;
  assign rise     = sync2 & ~prev;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of sig_in over a fixed clk gate window and flags the result in or out of range.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned EXP_MIN     = DEF_EXP_MIN,
  parameter int unsigned EXP_MAX     = DEF_EXP_MAX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sig_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edge_count,
  output logic             in_range,
  output logic             overflow
);

  localparam int unsigned GATE_W = width_for(GATE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  MIN_C     = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(EXP_MAX);
  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);

  state_t            state;
  logic [GATE_W-1:0] gate;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;
  logic              rise;
  logic              sync_unused;

  logic [CNT_W-1:0]  cnt_nxt;
  logic              ovf_nxt;
  logic              range_nxt;
  logic              sat;

  sync_edge_det u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (sig_in),
    .sync_out (sync_unused),
    .rise     (rise)
  );

  // Saturating count including this cycle's edge; also feeds the final result.
  assign sat       = (cnt == CNT_MAX);
  assign cnt_nxt   = (rise && !sat) ? cnt + CNT_W'(1) : cnt;
  assign ovf_nxt   = ovf | (rise & sat);
  assign range_nxt = !ovf_nxt && (cnt_nxt >= MIN_C) && (cnt_nxt <= MAX_C);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      gate       <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      edge_count <= '0;
      in_range   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= MEASURE;
            busy  <= 1'b1;
            gate  <= GATE_LOAD;
            cnt   <= '0;
            ovf   <= 1'b0;
          end
        end
        MEASURE: begin
          cnt <= cnt_nxt;
          ovf <= ovf_nxt;
          if (gate == '0) begin
            // Last gate cycle: its edge is already folded into cnt_nxt.
            state      <= REPORT;
            done       <= 1'b1;
            edge_count <= cnt_nxt;
            overflow   <= ovf_nxt;
            in_range   <= range_nxt;
          end else begin
            gate <= gate - GATE_W'(1);
          end
        end
        REPORT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: an 8-bit and a 4-bit counter instance share stimulus and a window-level model.
module tb_freq_meter;

  localparam int G       = 100;
  localparam int EXP_LO  = 12;
  localparam int EXP_HI  = 13;
  localparam int HIST_N  = 8192;

  logic       clk;
  logic       reset;
  logic       start;
  logic       sig_in;

  logic       busy8, done8, rng8, ovf8;
  logic [7:0] ec8;
  logic       busy4, done4, rng4, ovf4;
  logic [3:0] ec4;

  freq_meter #(.GATE_CYCLES(G), .CNT_W(8), .EXP_MIN(EXP_LO), .EXP_MAX(EXP_HI)) dut8 (
    .clk(clk), .reset(reset), .start(start), .sig_in(sig_in),
    .busy(busy8), .done(done8), .edge_count(ec8), .in_range(rng8), .overflow(ovf8)
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .EXP_MIN(EXP_LO), .EXP_MAX(EXP_HI)) dut4 (
    .clk(clk), .reset(reset), .start(start), .sig_in(sig_in),
    .busy(busy4), .done(done4), .edge_count(ec4), .in_range(rng4), .overflow(ovf4)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_total++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // sig_in generator; all transitions land at t = 2 mod 10, never on a clk edge.
  int half = 20;
  bit hold_val = 1'b1;
  initial begin
    sig_in = 1'b0;
    #2;
    forever begin
      if (half == 0) begin
        sig_in = hold_val;
        #10;
      end else begin
        #(half) sig_in = ~sig_in;
      end
    end
  end

  // Window model: sig_in samples per clk edge; rises counted on the two-flop-delayed level.
  bit hist[HIST_N];
  int e = 0;
  bit m_active = 1'b0;
  int ws = 0;
  bit exp_busy = 1'b0, exp_done = 1'b0;
  int exp_cnt8 = 0, exp_cnt4 = 0;
  bit exp_ovf8 = 1'b0, exp_ovf4 = 1'b0, exp_rng8 = 1'b0, exp_rng4 = 1'b0;

  function automatic bit s(input int j);
    return (j < 1 || j >= HIST_N) ? 1'b0 : hist[j];
  endfunction

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      e = 0; m_active = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
      exp_cnt8 = 0; exp_cnt4 = 0; exp_ovf8 = 1'b0; exp_ovf4 = 1'b0;
      exp_rng8 = 1'b0; exp_rng4 = 1'b0;
    end else begin
      int raw;
      e++;
      if (e < HIST_N) hist[e] = sig_in;
      exp_done = 1'b0;
      if (m_active && e == ws + G + 1) m_active = 1'b0;
      else if (!m_active && start) begin
        m_active = 1'b1;
        ws = e;
      end
      if (m_active && e == ws + G) begin
        raw = 0;
        for (int k = ws + 1; k <= ws + G; k++) raw += (s(k - 2) && !s(k - 3)) ? 1 : 0;
        exp_ovf8 = (raw > 255);
        exp_cnt8 = exp_ovf8 ? 255 : raw;
        exp_rng8 = !exp_ovf8 && exp_cnt8 >= EXP_LO && exp_cnt8 <= EXP_HI;
        exp_ovf4 = (raw > 15);
        exp_cnt4 = exp_ovf4 ? 15 : raw;
        exp_rng4 = !exp_ovf4 && exp_cnt4 >= EXP_LO && exp_cnt4 <= EXP_HI;
        exp_done = 1'b1;
      end
      exp_busy = m_active;
    end
  end

  // Per-cycle comparison of both instances against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("outputs8 {busy,done,ovf,rng,cnt}",
        int'({busy8, done8, ovf8, rng8, ec8}),
        int'({exp_busy, exp_done, exp_ovf8, exp_rng8, 8'(exp_cnt8)}));
    chk("outputs4 {busy,done,ovf,rng,cnt}",
        int'({busy4, done4, ovf4, rng4, ec4}),
        int'({exp_busy, exp_done, exp_ovf4, exp_rng4, 4'(exp_cnt4)}));
    if (done8) begin
      done_cnt++;
      done_q.push_back(cyc);
    end
  end

  task automatic pulse_start(output int c0);
    @(posedge clk);
    #1;
    c0 = cyc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int lat);
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    lat = -1;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      if (done8) got = 1'b1;
    end
    if (!got) chk("done_timeout", 0, 1);
    else lat = cyc - c0;
  endtask

  task automatic measure(input string name, output int lat);
    int c0;
    pulse_start(c0);
    chk({name, "_busy_after_start"}, int'(busy8), 1);
    wait_done(c0, lat);
  endtask

  initial begin
    int lat, c0, d0, n;
    reset = 1'b0;
    start = 1'b0;
    half = 20;

    // Reset held with sig_in toggling.
    #21;
    chk("reset_outputs8", int'({busy8, done8, ovf8, rng8, ec8}), 0);
    chk("reset_outputs4", int'({busy4, done4, ovf4, rng4, ec4}), 0);
    #1 reset = 1'b1;
    repeat (5) @(posedge clk);

    // Nominal 80 ns period.
    half = 40;
    repeat (10) @(posedge clk);
    measure("nominal", lat);
    chk("nominal_done_latency", lat, 101);
    chk_range("nominal_count", int'(ec8), 12, 13);
    chk("nominal_in_range", int'(rng8), 1);
    chk("nominal_overflow", int'(ovf8), 0);

    // Slow 160 ns period.
    half = 80;
    repeat (20) @(posedge clk);
    measure("slow", lat);
    chk_range("slow_count", int'(ec8), 6, 7);
    chk("slow_in_range", int'(rng8), 0);

    // Stopped input held high.
    half = 0;
    repeat (20) @(posedge clk);
    measure("stopped", lat);
    chk("stopped_count", int'(ec8), 0);
    chk("stopped_in_range", int'(rng8), 0);

    // 40 ns period: 25 edges saturate the 4-bit counter.
    half = 20;
    repeat (10) @(posedge clk);
    measure("fast", lat);
    chk("fast_count8", int'(ec8), 25);
    chk("fast_in_range8", int'(rng8), 0);
    chk("ovf_count4", int'(ec4), 15);
    chk("ovf_flag4", int'(ovf4), 1);
    chk("ovf_in_range4", int'(rng4), 0);

    // Second start during MEASURE is ignored.
    half = 40;
    repeat (10) @(posedge clk);
    d0 = done_cnt;
    pulse_start(c0);
    repeat (30) @(posedge clk);
    pulse_start(c0);
    repeat (250) @(negedge clk);
    chk("single_done_pulse", done_cnt - d0, 1);

    // Start held high: back-to-back windows.
    done_q.delete();
    @(posedge clk);
    #1 start = 1'b1;
    n = 0;
    while (done_q.size() < 2 && n < 400) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (done_q.size() < 2) chk("held_start_timeout", 0, 1);
    else chk("held_start_spacing", done_q[1] - done_q[0], 102);
    repeat (130) @(posedge clk);

    // Reset in the middle of a window.
    pulse_start(c0);
    repeat (50) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midreset_busy", int'(busy8), 0);
    chk("midreset_outputs", int'({done8, ovf8, rng8, ec8}), 0);
    #15 reset = 1'b1;
    d0 = done_cnt;
    repeat (150) @(negedge clk);
    chk("midreset_no_done", done_cnt - d0, 0);
    measure("after_reset", lat);
    chk_range("after_reset_count", int'(ec8), 12, 13);
    chk("after_reset_in_range", int'(rng8), 1);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency of a clock-like signal (e.g. the 6 MHz output of the clock generator) by counting its rising edges over a fixed gate window of the system clock.
- Reports the edge count and a pass/fail range flag.
- Sits on the consumer side of the clock generator as an on-chip self-check of the generated clock.
- Results go to status LEDs/display logic.

Parameters:
- GATE_CYCLES, 48000, gate window length in clk cycles (1 ms at 48 MHz).
- CNT_W, 16, width of edge counter and edge_count output.
- EXP_MIN, 5990, lowest edge count accepted as in range (inclusive).
- EXP_MAX, 6010, highest edge count accepted as in range (inclusive).

Ports:
- clk  input  1  system clock (48 MHz HSOSC domain).
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a measurement; sampled only in IDLE.
- sig_in  input  1  signal under test; asynchronous to clk.
- busy  output  1  high while a measurement is in progress.
- done  output  1  one-cycle pulse when results become valid.
- edge_count  output  CNT_W  rising edges counted in the last window.
- in_range  output  1  EXP_MIN <= edge_count <= EXP_MAX and no overflow.
- overflow  output  1  edge counter saturated during the last window.

Behaviour:
- Reset:
  - Asynchronous on reset=0.
  - State=IDLE; busy=0, done=0, edge_count=0, in_range=0, overflow=0.
  - Synchronizer and edge-detect flops all 0.
- Input conditioning:
  - sig_in passes through a 2-flop synchronizer, then a 1-flop history.
  - rise = sync2 & ~prev.
  - Edges are defined on the synchronized signal; an edge near the window end may fall outside it (±1 count tolerance is inherent).
- FSM states: IDLE, MEASURE, REPORT.
- IDLE:
  - start=1 at edge N -> MEASURE at N+1.
  - Gate counter loads GATE_CYCLES-1; edge counter clears to 0; overflow flag clears.
- MEASURE:
  - Lasts exactly GATE_CYCLES cycles.
  - Each cycle with rise=1 increments the edge counter.
  - At the counter value 2^CNT_W-1 the count holds and the internal overflow flag sets.
  - Gate counter decrements each cycle. When it is 0, the current cycle's rise still counts, then -> REPORT.
- REPORT (one cycle):
  - done=1.
  - edge_count, overflow, and in_range are registered from the final count and become visible in this cycle.
  - Next cycle -> IDLE.
- Output timing:
  - busy=1 in MEASURE and REPORT.
  - done is high in cycle N+GATE_CYCLES+1.
  - Result outputs hold their values until the next REPORT; they are not cleared by start.
- start while busy: ignored, not queued.
- start held high continuously: back-to-back measurements, one IDLE cycle between each.
- Reset mid-MEASURE: measurement aborted; all outputs return to reset values immediately.
- in_range is forced 0 when overflow=1.
- Comparisons are unsigned at CNT_W width.

Decomposition:
- Package freq_meter_pkg:
  - State enum typedef (IDLE, MEASURE, REPORT).
  - Default constants for 48 MHz clk / 6 MHz target.
- Sub-module sync_edge_det:
  - Ports: clk, reset, async_in, sync_out, rise.
  - Contains the 2-flop synchronizer plus the rising-edge detector.
  - Reused by future button/switch inputs.

Test Plan (sim parameters GATE_CYCLES=100, CNT_W=8, EXP_MIN=12, EXP_MAX=13, clk period 10 ns):
- Reset check: hold reset=0 for 22 ns with sig_in toggling -> busy=0, done=0, edge_count=0, in_range=0, overflow=0 throughout; no state change.
- Nominal frequency: sig_in period 80 ns (8 clk), pulse start one cycle -> busy=1 next cycle; done pulses exactly 101 cycles after start; edge_count is 12 or 13; in_range=1.
- Slow / stopped input:
  - sig_in period 160 ns -> edge_count is 6 or 7, in_range=0.
  - sig_in held at 1 -> edge_count=0, in_range=0.
- Overflow: CNT_W=4, sig_in period 40 ns (25 edges) -> edge_count=15, overflow=1, in_range=0.
- Handshake edges:
  - start pulsed again during MEASURE -> ignored; exactly one done pulse.
  - start held high -> done pulses spaced 102 cycles apart.
- Reset mid-operation: assert reset=0 at cycle 50 of MEASURE -> busy drops to 0 asynchronously; no done pulse; the next full measurement returns 12 or 13.
